mem_write_checker: RTL and testbench
====================================

# mem_write_checker

Parametrised self-checking monitor for the processor's data-memory write port, the successor of the single hard-wired "7 to address 84" check in the pipelined-core bench. It holds an ordered list of DEPTH expected (address, data) stores and an ignore window for scratch traffic, and compares every qualifying `memwrite` against the list head. It flags pass/fail with a diagnostic code and a watchdog timeout. It sits beside `top` in core testbenches and is synthesizable for on-FPGA self-test.

## Interface
- `WIDTH`, 32: address/data width.
- `DEPTH`, 8: maximum number of expected stores.
- `TIMEOUT`, 1024: RUN-state cycle limit; 0 disables the watchdog.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `clear`  in  1  synchronous return to IDLE; empties the list and zeroes the counters.
- `cfg_we`  in  1  push one expected entry (accepted in IDLE/LOAD only).
- `cfg_adr`, `cfg_data`  in  WIDTH  expected store address/data.
- `ign_adr`, `ign_mask`  in  WIDTH  ignore window; write ignored when `(dataadr & ign_mask) == (ign_adr & ign_mask)`; `ign_mask=0` means ignore none. Held static in RUN.
- `start`  in  1  arm checking.
- `memwrite`  in  1  DUT store strobe.
- `dataadr`, `writedata`  in  WIDTH  DUT store address/data.
- `busy`  out  1  high in RUN.
- `pass`, `fail`  out  1  sticky result flags.
- `fail_code`  out  2  00 none, 01 mismatch, 10 timeout, 11 config error.
- `fail_adr`, `fail_data`  out  WIDTH  offending store (mismatch only, else 0).
- `write_count`  out  16  qualifying stores seen in RUN, ignored ones included; saturates at FFFF.
- `entries`  out  $clog2(DEPTH+1)  entries currently pending.

## Operation
- States: IDLE, LOAD, RUN, PASS, FAIL.
- IDLE: the first `cfg_we` pushes an entry and moves to LOAD.
- IDLE/LOAD: `cfg_we` pushes; pushing when `entries==DEPTH` drops the entry and moves to FAIL with code 11.
- IDLE/LOAD: `start` moves to RUN. If `entries==0` after any same-cycle push, it moves to FAIL with code 11 instead.
- `cfg_we` and `start` in the same cycle: the push happens first, then `start` is evaluated.
- RUN, on `memwrite`:
  - increment `write_count`.
  - inside the ignore window: no other action.
  - else address and data equal to the head: pop; if this was the last entry, move to PASS.
  - else: move to FAIL with code 01, and latch `dataadr`/`writedata` into `fail_adr`/`fail_data`.
- The ignore check has priority over the compare. A store to an ignored address never matches the list.
- RUN watchdog:
  - the cycle counter starts at 0 on entry to RUN.
  - if the counter reaches TIMEOUT with entries pending and no completing write that cycle, move to FAIL with code 10.
  - a write that empties the list on the expiry cycle wins, and the result is PASS.
- PASS/FAIL are terminal: `memwrite`, `cfg_we` and `start` are ignored, and outputs hold until `clear` or `reset`.
- `clear` is allowed in any state and has priority over every other input that cycle.
- `memwrite` outside RUN is not counted.
- `reset` in any state, including mid-RUN, forces IDLE immediately.
- Reset values: all outputs 0, the list is empty, the watchdog counter is 0.

## Timing
- Inputs are sampled on the rising edge.
- All outputs are registered. A flag or state change caused by a write sampled at edge N is visible after edge N.
- `pass`/`fail` assert one edge after the deciding write. They are never high together.
- A push at edge N is reflected in `entries` after edge N.
- `start` at edge N gives `busy` high after edge N.
- Timeout asserts `fail` at the edge where the RUN cycle count equals TIMEOUT, counted from the `start` edge.
- Back-to-back writes on consecutive cycles are supported, one compare per cycle, with no stall.

## Structure
- Package `mem_check_pkg` holds:
  - `state_t` enum {IDLE, LOAD, RUN, PASS, FAIL}.
  - `fail_code_t` values FC_NONE/FC_MISMATCH/FC_TIMEOUT/FC_CONFIG.
  - width of the `write_count` counter.
- Sub-module `exp_fifo`: synchronous FIFO, DEPTH×(2·WIDTH). It has push/pop/flush, `head`, `count`, `full`, `empty`, async reset, and supports simultaneous push and pop.
- Top-level FSM, watchdog counter and compare logic live in `mem_write_checker`.

## Test plan
- Ignore window 80, mask FFFFFFFF, one expected entry {84,7}; start; writes 80/3, 80/9, then 84/7 → pass=1, fail_code=00, write_count=3, entries=0.
- Same setup; write 84/6 → fail=1, fail_code=01, fail_adr=84, fail_data=6; a later write 84/7 does not change any output.
- Ordered list {0,1},{4,2},{8,3}, ign_mask=0; writes 0/1, 8/3 → fail code 01 with fail_adr=8. Rerun with in-order writes → pass after the third write.
- Watchdog:
  - TIMEOUT=16, one entry, no writes → fail_code=10 exactly 16 edges after start.
  - Variant: the matching write lands on the 16th cycle → pass, not fail.
- Config errors:
  - DEPTH=4, five `cfg_we` pushes → fail_code=11, entries=4.
  - `start` with an empty list → fail_code=11.
  - `cfg_we` together with `start` and an empty list → RUN with entries=1.
- Reset and clear:
  - `reset` pulse mid-RUN with 2 entries pending → all outputs 0, busy=0, and a write to 84/7 afterwards is not counted.
  - `clear` from PASS → IDLE with entries=0.

Source files
------------

// File: rtl/mem_check_pkg.sv
// Shared types for the data-memory write checker: FSM states, failure codes, counter width.
package mem_check_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PASS,
        FAIL
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISMATCH = 2'b01,
        FC_TIMEOUT  = 2'b10,
        FC_CONFIG   = 2'b11
    } fail_code_t;

    localparam int WC_W = 16;

endpackage

// File: rtl/exp_fifo.sv
// Ordered list of expected stores: synchronous FIFO with flush and same-cycle push/pop.
module exp_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A full FIFO still accepts a push when a pop frees a slot that same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the data-memory write port against an ordered list of expected stores,
// with an ignore window for scratch traffic and a RUN-state watchdog.
module mem_write_checker
    import mem_check_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       cfg_we,
    input  logic [WIDTH-1:0]           cfg_adr,
    input  logic [WIDTH-1:0]           cfg_data,
    input  logic [WIDTH-1:0]           ign_adr,
    input  logic [WIDTH-1:0]           ign_mask,
    input  logic                       start,
    input  logic                       memwrite,
    input  logic [WIDTH-1:0]           dataadr,
    input  logic [WIDTH-1:0]           writedata,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [WIDTH-1:0]           fail_adr,
    output logic [WIDTH-1:0]           fail_data,
    output logic [WC_W-1:0]            write_count,
    output logic [$clog2(DEPTH+1)-1:0] entries
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t             state;
    logic [TW-1:0]      wd_count;
    logic [2*WIDTH-1:0] head;
    logic               full;
    logic               empty;
    logic               cfg_phase;
    logic               push;
    logic               pop;
    logic               ignored;
    logic               match;
    logic               hit;
    logic               last;
    logic               expire;

    always_comb begin
        cfg_phase = (state == IDLE) || (state == LOAD);
        // A zero mask would make the window match everything, so it means "no window".
        ignored   = (ign_mask != '0) && ((dataadr & ign_mask) == (ign_adr & ign_mask));
        match     = !empty && (head == {dataadr, writedata});
        hit       = (state == RUN) && memwrite && !ignored && match;
        last      = (entries == CW'(1));
        push      = !clear && cfg_phase && cfg_we && !full;
        pop       = !clear && hit;
        expire    = (TIMEOUT != 0) && ((32'(wd_count) + 32'd1) == 32'(TIMEOUT));
    end

    exp_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_exp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (clear),
        .din   ({cfg_adr, cfg_data}),
        .head  (head),
        .count (entries),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= FC_NONE;
            fail_adr    <= '0;
            fail_data   <= '0;
            write_count <= '0;
            wd_count    <= '0;
        end else if (clear) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= FC_NONE;
            fail_adr    <= '0;
            fail_data   <= '0;
            write_count <= '0;
            wd_count    <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (cfg_we && full) begin
                        state     <= FAIL;
                        fail      <= 1'b1;
                        fail_code <= FC_CONFIG;
                    end else if (start) begin
                        // A same-cycle push already makes the list non-empty.
                        if (empty && !cfg_we) begin
                            state     <= FAIL;
                            fail      <= 1'b1;
                            fail_code <= FC_CONFIG;
                        end else begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            wd_count <= '0;
                        end
                    end else if (cfg_we) begin
                        state <= LOAD;
                    end
                end
                RUN: begin
                    wd_count <= wd_count + TW'(1);
                    if (memwrite && (write_count != '1))
                        write_count <= write_count + WC_W'(1);
                    if (memwrite && !ignored && !match) begin
                        state     <= FAIL;
                        busy      <= 1'b0;
                        fail      <= 1'b1;
                        fail_code <= FC_MISMATCH;
                        fail_adr  <= dataadr;
                        fail_data <= writedata;
                    end else if (hit && last) begin
                        state <= PASS;
                        busy  <= 1'b0;
                        pass  <= 1'b1;
                    end else if (expire) begin
                        state     <= FAIL;
                        busy      <= 1'b0;
                        fail      <= 1'b1;
                        fail_code <= FC_TIMEOUT;
                    end
                end
                PASS, FAIL: state <= state;
                default:    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker (DEPTH=4, TIMEOUT=16) with hand-computed expectations.
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        cfg_we;
    logic [31:0] cfg_adr;
    logic [31:0] cfg_data;
    logic [31:0] ign_adr;
    logic [31:0] ign_mask;
    logic        start;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_code;
    logic [31:0] fail_adr;
    logic [31:0] fail_data;
    logic [15:0] write_count;
    logic [2:0]  entries;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_write_checker #(
        .WIDTH   (32),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .cfg_we      (cfg_we),
        .cfg_adr     (cfg_adr),
        .cfg_data    (cfg_data),
        .ign_adr     (ign_adr),
        .ign_mask    (ign_mask),
        .start       (start),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .fail_code   (fail_code),
        .fail_adr    (fail_adr),
        .fail_data   (fail_data),
        .write_count (write_count),
        .entries     (entries)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_adr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        step();
        memwrite = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; cfg_we = 1'b0; cfg_adr = '0; cfg_data = '0;
        ign_adr = 32'd80; ign_mask = 32'hFFFF_FFFF; start = 1'b0;
        memwrite = 1'b0; dataadr = '0; writedata = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_code", fail_code, 0);
        chk("rst_wc", write_count, 0);
        chk("rst_entries", entries, 0);
        reset = 1'b0;
        step();

        // Ignore window 80, expect {84,7}
        push(32'd84, 32'd7);
        chk("t1_entries", entries, 1);
        do_start();
        chk("t1_busy", busy, 1);
        wr(32'd80, 32'd3);
        wr(32'd80, 32'd9);
        chk("t1_pass_early", pass, 0);
        wr(32'd84, 32'd7);
        chk("t1_pass", pass, 1);
        chk("t1_fail", fail, 0);
        chk("t1_code", fail_code, 0);
        chk("t1_wc", write_count, 3);
        chk("t1_entries_end", entries, 0);
        chk("t1_busy_end", busy, 0);
        do_clear();
        chk("clr_pass", pass, 0);
        chk("clr_wc", write_count, 0);

        // Mismatch 84/6, later writes ignored
        push(32'd84, 32'd7);
        do_start();
        wr(32'd84, 32'd6);
        chk("t2_fail", fail, 1);
        chk("t2_code", fail_code, 1);
        chk("t2_adr", fail_adr, 84);
        chk("t2_data", fail_data, 6);
        chk("t2_wc", write_count, 1);
        wr(32'd84, 32'd7);
        chk("t2_fail_hold", fail, 1);
        chk("t2_pass_hold", pass, 0);
        chk("t2_code_hold", fail_code, 1);
        chk("t2_data_hold", fail_data, 6);
        chk("t2_wc_hold", write_count, 1);
        chk("t2_entries_hold", entries, 1);
        do_clear();

        // Ordered list, out-of-order write fails
        ign_mask = '0;
        push(32'd0, 32'd1);
        push(32'd4, 32'd2);
        push(32'd8, 32'd3);
        chk("t3_entries", entries, 3);
        do_start();
        wr(32'd0, 32'd1);
        chk("t3_pop", entries, 2);
        wr(32'd8, 32'd3);
        chk("t3_code", fail_code, 1);
        chk("t3_adr", fail_adr, 8);
        chk("t3_data", fail_data, 3);
        do_clear();
        push(32'd0, 32'd1);
        push(32'd4, 32'd2);
        push(32'd8, 32'd3);
        do_start();
        wr(32'd0, 32'd1);
        wr(32'd4, 32'd2);
        chk("t3b_pass_early", pass, 0);
        wr(32'd8, 32'd3);
        chk("t3b_pass", pass, 1);
        chk("t3b_wc", write_count, 3);
        do_clear();

        // Watchdog expiry 16 edges after start
        push(32'd84, 32'd7);
        do_start();
        repeat (15) step();
        chk("t4_fail_early", fail, 0);
        chk("t4_busy_early", busy, 1);
        step();
        chk("t4_fail", fail, 1);
        chk("t4_code", fail_code, 2);
        chk("t4_busy", busy, 0);
        chk("t4_adr", fail_adr, 0);
        do_clear();

        // Completing write on the expiry cycle wins
        push(32'd84, 32'd7);
        do_start();
        repeat (15) step();
        wr(32'd84, 32'd7);
        chk("t4b_pass", pass, 1);
        chk("t4b_fail", fail, 0);
        chk("t4b_code", fail_code, 0);
        do_clear();

        // Overflow on fifth push
        push(32'd0, 32'd1);
        push(32'd4, 32'd2);
        push(32'd8, 32'd3);
        push(32'd12, 32'd4);
        chk("t5_full", entries, 4);
        chk("t5_fail_early", fail, 0);
        push(32'd16, 32'd5);
        chk("t5_fail", fail, 1);
        chk("t5_code", fail_code, 3);
        chk("t5_entries", entries, 4);
        do_clear();

        // Start with an empty list
        do_start();
        chk("t5b_fail", fail, 1);
        chk("t5b_code", fail_code, 3);
        chk("t5b_busy", busy, 0);
        do_clear();

        // Push together with start on an empty list
        cfg_we = 1'b1; cfg_adr = 32'd84; cfg_data = 32'd7; start = 1'b1;
        step();
        cfg_we = 1'b0; start = 1'b0;
        chk("t5c_busy", busy, 1);
        chk("t5c_entries", entries, 1);
        chk("t5c_fail", fail, 0);
        do_clear();

        // Asynchronous reset mid-RUN
        push(32'd0, 32'd1);
        push(32'd4, 32'd2);
        do_start();
        chk("t6_busy", busy, 1);
        chk("t6_entries", entries, 2);
        reset = 1'b1;
        #2;
        chk("t6_async_busy", busy, 0);
        chk("t6_async_entries", entries, 0);
        reset = 1'b0;
        wr(32'd84, 32'd7);
        chk("t6_wc", write_count, 0);
        chk("t6_pass", pass, 0);
        chk("t6_fail", fail, 0);
        chk("t6_busy_after", busy, 0);

        // Clear from PASS back to IDLE
        push(32'd84, 32'd7);
        do_start();
        wr(32'd84, 32'd7);
        chk("t7_pass", pass, 1);
        do_clear();
        chk("t7_pass_clr", pass, 0);
        chk("t7_entries", entries, 0);
        push(32'd84, 32'd7);
        chk("t7_repush", entries, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
